// File: rtl/tlul_fuzz_host.sv
// tlul_pkg: minimal TL-UL type package for the fuzz harness (widths match the AES register bus).
//
// tlul_fuzz_host: turns decoded fuzzer commands (NOP / WAIT / READ / WRITE) into single-outstanding
// TL-UL host transactions and reports each completion back to the harness.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake (ready only while idle)
//   cmd_op_i               0=NOP, 1=WAIT, 2=READ, 3=WRITE
//   cmd_addr_i             register byte address (READ/WRITE)
//   cmd_data_i             write data; low WaitCntWidth bits are the WAIT count
//   tl_o / tl_i            TL-UL host request / device response
//   rsp_valid_o            one-cycle completion pulse for READ/WRITE (incl. timeout)
//   rsp_data_o, rsp_err_o  registered read data and error flag of the last completion
//   timeout_o              sticky timeout flag, cleared only by reset
//   busy_o                 high whenever the FSM is not idle

package tlul_pkg;

    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_AIW = 8;
    parameter int TL_DIW = 1;
    parameter int TL_DBW = 4;
    parameter int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    parameter tl_a_user_t TL_A_USER_DEFAULT = '{
        rsvd:       5'h0,
        instr_type: 4'h9,
        cmd_intg:   7'h0,
        data_intg:  7'h0
    };

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

module tlul_fuzz_host #(
    parameter int unsigned SrcWidth      = 8,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned WaitCntWidth  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [31:0]       cmd_addr_i,
    input  logic [31:0]       cmd_data_i,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic              timeout_o,
    output logic              busy_o
);

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpWait  = 2'd1;
    localparam logic [1:0] OpRead  = 2'd2;
    localparam logic [1:0] OpWrite = 2'd3;

    // One extra bit so TimeoutCycles-1 always fits, whatever the parameter value.
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {StIdle, StWait, StReq, StRsp} state_e;

    state_e                  state_q, state_d;
    logic [WaitCntWidth-1:0] wait_cnt_q, wait_cnt_d;
    logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    is_write_q, is_write_d;
    logic [SrcWidth-1:0]     src_q, src_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    timeout_q, timeout_d;
    logic                    a_valid;
    logic                    d_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            is_write_q  <= 1'b0;
            src_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            is_write_q  <= is_write_d;
            src_q       <= src_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_write_d  = is_write_q;
        src_d       = src_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        timeout_d   = timeout_q;
        cmd_ready_o = 1'b0;
        a_valid     = 1'b0;
        d_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                tmo_cnt_d   = '0;
                if (cmd_valid_i) begin
                    unique case (cmd_op_i)
                        OpWait: begin
                            // A zero count is a no-op: never leave idle.
                            if (cmd_data_i[WaitCntWidth-1:0] != '0) begin
                                wait_cnt_d = cmd_data_i[WaitCntWidth-1:0];
                                state_d    = StWait;
                            end
                        end
                        OpRead, OpWrite: begin
                            addr_d     = cmd_addr_i;
                            data_d     = cmd_data_i;
                            is_write_d = (cmd_op_i == OpWrite);
                            state_d    = StReq;
                        end
                        OpNop: ;
                        default: ;
                    endcase
                end
            end

            StWait: begin
                // Counter holds N on the first wait cycle, so N cycles are spent here.
                if (wait_cnt_q == WaitCntWidth'(1)) begin
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q - WaitCntWidth'(1);
                end
            end

            StReq: begin
                a_valid = 1'b1;
                // The handshake takes priority over a timeout in the same cycle.
                if (tl_i.a_ready) begin
                    tmo_cnt_d = '0;
                    state_d   = StRsp;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_cnt_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end

            StRsp: begin
                d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    tmo_cnt_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = is_write_q ? 32'h0 : tl_i.d_data;
                    rsp_err_d   = tl_i.d_error;
                    src_d       = src_q + SrcWidth'(1);
                    state_d     = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_cnt_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // A-channel fields come straight from registers, so they stay stable while a_valid waits.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_opcode  = is_write_q ? tlul_pkg::PutFullData : tlul_pkg::Get;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = tlul_pkg::TL_SZW'(2);
        tl_o.a_source  = tlul_pkg::TL_AIW'(src_q);
        tl_o.a_address = {addr_q[31:2], 2'b00};
        tl_o.a_mask    = 4'hF;
        tl_o.a_data    = is_write_q ? data_q : 32'h0;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = d_ready;
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = (state_q != StIdle);

    // Response metadata the host does not need.
    logic unused_tl;
    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink,
                         tl_i.d_user};

endmodule

// File: tb/tb_tlul_fuzz_host.sv
module tb_tlul_fuzz_host;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_WAIT  = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd3;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_data;
    tlul_pkg::tl_h2d_t tl_o;
    tlul_pkg::tl_d2h_t tl_i;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              timeout;
    logic              busy;

    tlul_fuzz_host #(
        .SrcWidth      (8),
        .TimeoutCycles (256),
        .WaitCntWidth  (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .tl_o        (tl_o),
        .tl_i        (tl_i),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .timeout_o   (timeout),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  src;
    } a_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } r_exp_t;

    a_exp_t     a_q[$];
    r_exp_t     r_q[$];
    a_exp_t     ea;
    r_exp_t     er;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_rsp = 0;
    int         rsp_cyc = 0;
    int         cyc = 0;
    logic [7:0] src_exp = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: A-channel requests and completions are popped as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tl_o.a_valid && tl_i.a_ready) begin
                if (a_q.size() == 0) begin
                    check("a_unexpected", 32'd1, 32'd0);
                end else begin
                    ea = a_q.pop_front();
                    check("a_opcode", 32'(tl_o.a_opcode), 32'(ea.op));
                    check("a_address", tl_o.a_address, ea.addr);
                    check("a_data", tl_o.a_data, ea.data);
                    check("a_source", 32'(tl_o.a_source), 32'(ea.src));
                    check("a_mask", 32'(tl_o.a_mask), 32'hF);
                    check("a_size", 32'(tl_o.a_size), 32'd2);
                end
            end
            if (rsp_valid) begin
                n_rsp++;
                rsp_cyc = cyc;
                if (r_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    er = r_q.pop_front();
                    check("rsp_data", rsp_data, er.data);
                    check("rsp_err", 32'(rsp_err), 32'(er.err));
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rw(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] rdat, input bit derr, input int dly);
        int n0;
        a_q.push_back('{op: (wr ? 3'd0 : 3'd4), addr: {addr[31:2], 2'b00},
                        data: (wr ? data : 32'h0), src: src_exp});
        r_q.push_back('{data: (wr ? 32'h0 : rdat), err: derr});
        src_exp = src_exp + 8'd1;
        n0 = n_rsp;
        send_cmd(wr ? OP_WRITE : OP_READ, addr, data);
        tl_i.a_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.a_ready = 1'b0;
        check("d_ready_rsp", 32'(tl_o.d_ready), 32'd1);
        repeat (dly) begin @(posedge clk); #1; end
        tl_i.d_valid = 1'b1;
        tl_i.d_data  = rdat;
        tl_i.d_error = derr;
        @(posedge clk); #1;
        tl_i.d_valid = 1'b0;
        tl_i.d_data  = 32'h0;
        tl_i.d_error = 1'b0;
        check("rsp_pulse", 32'(rsp_valid), 32'd1);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("rsp_single", 32'(rsp_valid), 32'd0);
        check("rsp_count", n_rsp, n0 + 1);
    endtask

    initial begin
        int n0;
        int c_req;
        int busy_cnt;
        int nrdy_cnt;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h0;
        tl_i      = '0;
        rst_n     = 1'b0;

        // Reset state
        #12;
        check("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
        check("rst_d_ready", 32'(tl_o.d_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;

        // WRITE then READ (unaligned address), source 0 then 1
        rw(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, 2);
        rw(1'b0, 32'h0000_0007, 32'h5555_5555, 32'h1234_5678, 1'b0, 1);
        check("read_data_hold", rsp_data, 32'h1234_5678);

        // WAIT 5 with a NOP queued behind it
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = OP_WAIT; cmd_data = 32'd5;
        @(posedge clk); #1;
        cmd_op = OP_NOP;
        busy_cnt = 0; nrdy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            busy_cnt += int'(busy);
            nrdy_cnt += int'(!cmd_ready);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("wait5_busy", busy_cnt, 5);
        check("wait5_not_ready", nrdy_cnt, 5);

        // WAIT 0 never goes busy
        send_cmd(OP_WAIT, 32'h0, 32'h0);
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            busy_cnt += int'(busy);
            @(posedge clk); #1;
        end
        check("wait0_busy", busy_cnt, 0);

        // d_error on a READ
        rw(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1'b1, 0);
        check("derr_no_timeout", 32'(timeout), 32'd0);

        // Device never accepts the request
        r_q.push_back('{data: 32'h0, err: 1'b1});
        n0 = n_rsp;
        send_cmd(OP_READ, 32'h0000_0020, 32'h0);
        c_req = cyc;
        for (int i = 0; i < 300 && n_rsp == n0; i++) begin
            @(posedge clk); #1;
        end
        check("timeout_seen", n_rsp, n0 + 1);
        check("timeout_latency", rsp_cyc - c_req, 256);
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_a_valid", 32'(tl_o.a_valid), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);

        // Late d_valid is ignored
        tl_i.d_valid = 1'b1;
        tl_i.d_data  = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("late_d_ready", 32'(tl_o.d_ready), 32'd0);
        end
        tl_i.d_valid = 1'b0;
        tl_i.d_data  = 32'h0;
        @(posedge clk); #1;
        check("late_no_rsp", n_rsp, n0 + 1);

        // Timeout flag is sticky across a good transaction
        rw(1'b1, 32'h0000_0008, 32'h0BAD_CAFE, 32'h0, 1'b0, 0);
        check("timeout_sticky", 32'(timeout), 32'd1);

        // Source counter wrap 255 -> 0
        for (int i = 0; i < 257; i++) begin
            rw(i[0], 32'h100 + 32'(i * 4), 32'(i) ^ 32'hA5A5_0000, 32'(i) * 32'h0101_0101,
               1'b0, 0);
        end

        // Reset while waiting in the response phase
        a_q.push_back('{op: 3'd4, addr: 32'h0000_0040, data: 32'h0, src: src_exp});
        n0 = n_rsp;
        send_cmd(OP_READ, 32'h0000_0040, 32'h0);
        tl_i.a_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.a_ready = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_d_ready", 32'(tl_o.d_ready), 32'd0);
        check("arst_a_valid", 32'(tl_o.a_valid), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_rsp_data", rsp_data, 32'h0);
        check("arst_rsp_err", 32'(rsp_err), 32'd0);
        check("arst_source", 32'(tl_o.a_source), 32'd0);
        #3;
        rst_n = 1'b1;
        src_exp = 8'd0;
        check("arst_no_rsp", n_rsp, n0);
        rw(1'b1, 32'h0000_0044, 32'h1357_9BDF, 32'h0, 1'b0, 1);

        check("a_queue_empty", 32'(a_q.size()), 32'd0);
        check("r_queue_empty", 32'(r_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
